// File: rtl/uart_apb_if_pkg.sv
// Shared definitions for the APB-attached UART front end: register offsets,
// STATUS/CTRL bit positions and the TX launch FSM encoding.
package uart_apb_if_pkg;

    // Register select values (paddr[3:2])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // STATUS bit positions
    localparam int STS_TX_FULL  = 0;
    localparam int STS_TX_EMPTY = 1;
    localparam int STS_RX_FULL  = 2;
    localparam int STS_RX_EMPTY = 3;
    localparam int STS_RX_OVR   = 4;
    localparam int STS_TX_OVF   = 5;
    localparam int STS_TX_BUSY  = 6;

    // CTRL bit positions
    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_TXE_IE = 1;
    localparam int CTRL_OVR_IE = 2;

    // Down-counter load for the WAIT_HI guard: 3..0 gives four cycles
    localparam logic [1:0] TX_HI_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_LAUNCH  = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock 8-bit FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart by the MSB; a pop on an empty FIFO is ignored and a
// push on a full FIFO is accepted only when a pop frees a slot in the same
// cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);

    // Pointer update; wrap-around of the extra bit is intentional
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_apb_if.sv
// APB3 register front end for a byte UART: TX/RX FIFOs, sticky overflow
// flags, interrupt enables and the transmit launch sequencer.
//
// TX launch FSM
//   state   | meaning
//   IDLE    | waiting for a queued byte and an idle transmitter
//   LAUNCH  | one-cycle send strobe, head byte popped
//   WAIT_HI | waiting for tx_busy to rise (4-cycle guard back to IDLE)
//   WAIT_LO | frame on the line, waiting for tx_busy to fall
//
// Read data is captured in the APB setup cycle so prdata is stable for the
// whole access cycle; the RX pop is armed in setup and taken in access, so a
// read that saw an empty FIFO returns 0 and never pops.
module uart_apb_if #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [7:0]  pi_data,
    output logic        pi_flag,
    input  logic        tx_busy,
    input  logic [7:0]  po_data,
    input  logic        po_flag,
    output logic        irq
);

    import uart_apb_if_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   r_state;
    tx_state_e   w_state_nxt;
    logic [1:0]  r_tmr;
    logic [1:0]  w_tmr_nxt;

    logic [2:0]  r_ctrl;
    logic        r_rx_ovr;
    logic        r_tx_ovf;
    logic        r_rd_pop_arm;
    logic [31:0] r_prdata;
    logic [7:0]  r_pi_data;
    logic        r_pi_flag;
    logic        r_irq;

    logic        w_setup;
    logic        w_access;
    logic [1:0]  w_reg_sel;
    logic        w_wr_data;
    logic        w_wr_status;
    logic        w_wr_ctrl;
    logic        w_rd_data_setup;

    logic        w_tx_push;
    logic        w_tx_pop;
    logic [7:0]  w_tx_head;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic [CW-1:0] w_tx_count;

    logic        w_rx_pop;
    logic [7:0]  w_rx_head;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic [CW-1:0] w_rx_count;

    logic        w_tx_ovf_set;
    logic        w_rx_ovr_set;
    logic [31:0] w_status;
    logic [31:0] w_rd_mux;
    logic        w_irq_nxt;
    logic        w_unused;

    assign w_setup     = psel & ~penable;
    assign w_access    = psel & penable;
    assign w_reg_sel   = paddr[3:2];
    assign w_wr_data   = w_access & pwrite & (w_reg_sel == REG_DATA);
    assign w_wr_status = w_access & pwrite & (w_reg_sel == REG_STATUS);
    assign w_wr_ctrl   = w_access & pwrite & (w_reg_sel == REG_CTRL);
    assign w_rd_data_setup = w_setup & ~pwrite & (w_reg_sel == REG_DATA);

    assign w_tx_push = w_wr_data;
    assign w_tx_pop  = (r_state == TX_LAUNCH);
    assign w_rx_pop  = w_access & ~pwrite & (w_reg_sel == REG_DATA) & r_rd_pop_arm;

    // A drop happens only when full and nothing leaves in the same cycle
    assign w_tx_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop;
    assign w_rx_ovr_set = po_flag & w_rx_full & ~w_rx_pop;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_data  (pwdata[7:0]),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (po_flag),
        .i_pop   (w_rx_pop),
        .i_data  (po_data),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    // STATUS word assembly
    always_comb begin
        w_status = '0;
        w_status[STS_TX_FULL]  = w_tx_full;
        w_status[STS_TX_EMPTY] = w_tx_empty;
        w_status[STS_RX_FULL]  = w_rx_full;
        w_status[STS_RX_EMPTY] = w_rx_empty;
        w_status[STS_RX_OVR]   = r_rx_ovr;
        w_status[STS_TX_OVF]   = r_tx_ovf;
        w_status[STS_TX_BUSY]  = tx_busy;
    end

    // Read data select
    always_comb begin
        w_rd_mux = '0;
        case (w_reg_sel)
            REG_DATA:   w_rd_mux = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            REG_STATUS: w_rd_mux = w_status;
            REG_CTRL:   w_rd_mux = {29'h0, r_ctrl};
            REG_COUNT:  w_rd_mux = {9'h0, 7'(w_tx_count), 9'h0, 7'(w_rx_count)};
            default:    w_rd_mux = '0;
        endcase
    end

    // Read capture in setup and RX pop arming
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prdata     <= '0;
            r_rd_pop_arm <= 1'b0;
        end else begin
            if (w_setup & ~pwrite) r_prdata <= w_rd_mux;
            r_rd_pop_arm <= w_rd_data_setup & ~w_rx_empty;
        end
    end

    // Control register and sticky overflow flags (set beats clear)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl   <= '0;
            r_rx_ovr <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= pwdata[2:0];
            if (w_rx_ovr_set)
                r_rx_ovr <= 1'b1;
            else if (w_wr_status & pwdata[STS_RX_OVR])
                r_rx_ovr <= 1'b0;
            if (w_tx_ovf_set)
                r_tx_ovf <= 1'b1;
            else if (w_wr_status & pwdata[STS_TX_OVF])
                r_tx_ovf <= 1'b0;
        end
    end

    // TX FSM state and guard timer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= TX_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // TX FSM next state and guard timer
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            TX_IDLE: begin
                if (!w_tx_empty && !tx_busy) w_state_nxt = TX_LAUNCH;
            end
            TX_LAUNCH: begin
                w_state_nxt = TX_WAIT_HI;
                w_tmr_nxt   = TX_HI_TIMEOUT;
            end
            TX_WAIT_HI: begin
                if (tx_busy)
                    w_state_nxt = TX_WAIT_LO;
                else if (r_tmr == 2'd0)
                    w_state_nxt = TX_IDLE;
                else
                    w_tmr_nxt = r_tmr - 2'd1;
            end
            TX_WAIT_LO: begin
                if (!tx_busy) w_state_nxt = TX_IDLE;
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    // Send strobe and held byte, loaded on entry to LAUNCH
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pi_data <= '0;
            r_pi_flag <= 1'b0;
        end else begin
            r_pi_flag <= (w_state_nxt == TX_LAUNCH);
            if (w_state_nxt == TX_LAUNCH) r_pi_data <= w_tx_head;
        end
    end

    assign w_irq_nxt = (r_ctrl[CTRL_RX_IE]  & ~w_rx_empty) |
                       (r_ctrl[CTRL_TXE_IE] & w_tx_empty & (r_state == TX_IDLE)) |
                       (r_ctrl[CTRL_OVR_IE] & (r_rx_ovr | r_tx_ovf));

    // Registered interrupt level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_irq <= 1'b0;
        else       r_irq <= w_irq_nxt;
    end

    assign w_unused = &{1'b0, pwdata[31:8], paddr[1:0]};

    assign prdata  = r_prdata;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;
    assign pi_data = r_pi_data;
    assign pi_flag = r_pi_flag;
    assign irq     = r_irq;

endmodule

// File: tb/tb_uart_apb_if.sv
// Self-checking bench for uart_apb_if: scoreboard queues for TX launches and
// RX reads, directed scenarios for overflow, full-FIFO, irq and reset.
module tb_uart_apb_if;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  pi_data;
    logic        pi_flag;
    logic        tx_busy;
    logic [7:0]  po_data = '0;
    logic        po_flag = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;
    int flag_cnt = 0;

    logic model_en = 1'b0;
    logic busy_force = 1'b0;
    int   busy_cnt = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    uart_apb_if #(.FIFO_DEPTH(16)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .pi_data (pi_data),
        .pi_flag (pi_flag),
        .tx_busy (tx_busy),
        .po_data (po_data),
        .po_flag (po_flag),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy from the cycle after a strobe, for 100 cycles
    always @(posedge clk) begin
        if (!model_en)        busy_cnt <= 0;
        else if (pi_flag)     busy_cnt <= 100;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = model_en ? (busy_cnt != 0) : busy_force;

    always @(negedge clk) begin
        if (pi_flag === 1'b1) flag_cnt <= flag_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d,
                            input logic with_po = 1'b0, input logic [7:0] pd = 8'h00);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        if (with_po) begin po_flag = 1'b1; po_data = pd; end
        @(posedge clk); #1;
        po_flag = 1'b0;
        d = prdata;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        po_flag = 1'b1; po_data = b;
        @(posedge clk); #1;
        po_flag = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h required %h", prdata, 32'h0); end
        n_checks++; if (pi_flag !== 1'b0) begin n_fail++; $display("FAIL reset_pi_flag: got %b required 0", pi_flag); end
        n_checks++; if (pi_data !== 8'h00) begin n_fail++; $display("FAIL reset_pi_data: got %h required 00", pi_data); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b required 0", irq); end
        n_checks++; if ({pready, pslverr} !== 2'b10) begin n_fail++; $display("FAIL pready_pslverr: got %b required 10", {pready, pslverr}); end
        rstn = 1'b1;
        @(posedge clk); #1;
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL reset_status: got %h required %h", d, 32'h0A); end
        apb_read(4'h8, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", d); end
        apb_read(4'hC, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h required 0", d); end
    endtask

    task automatic test_tx_launch();
        int strobes = 0;
        logic [7:0] e;
        model_en = 1'b1;
        fork
            begin
                exp_tx.push_back(8'h41); apb_write(4'h0, 32'h41);
                exp_tx.push_back(8'h42); apb_write(4'h0, 32'h42);
            end
            begin
                for (int c = 0; c < 300; c++) begin
                    @(negedge clk);
                    if (pi_flag === 1'b1) begin
                        strobes++;
                        n_checks++;
                        if (exp_tx.size() == 0) begin
                            n_fail++; $display("FAIL tx_strobe_unexpected: got data %h required no strobe", pi_data);
                        end else begin
                            e = exp_tx.pop_front();
                            if (pi_data !== e) begin n_fail++; $display("FAIL tx_data: got %h required %h", pi_data, e); end
                        end
                        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL tx_strobe_while_busy: got busy %b required 0", tx_busy); end
                    end
                end
            end
        join
        n_checks++; if (strobes != 2) begin n_fail++; $display("FAIL tx_strobe_count: got %0d required 2", strobes); end
        n_checks++; if (exp_tx.size() != 0) begin n_fail++; $display("FAIL tx_left_in_queue: got %0d required 0", exp_tx.size()); end
        n_checks++; if (pi_data !== 8'h42) begin n_fail++; $display("FAIL tx_data_hold: got %h required 42", pi_data); end
        model_en = 1'b0;
        exp_tx.delete();
    endtask

    task automatic test_timeout();
        int cyc0 = -1;
        int cyc1 = -1;
        logic [7:0] e;
        model_en = 1'b0; busy_force = 1'b0;
        fork
            begin
                exp_tx.push_back(8'h31); apb_write(4'h0, 32'h31);
                exp_tx.push_back(8'h32); apb_write(4'h0, 32'h32);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (pi_flag === 1'b1) begin
                        if (cyc0 < 0) cyc0 = c; else if (cyc1 < 0) cyc1 = c;
                        n_checks++;
                        if (exp_tx.size() == 0) begin
                            n_fail++; $display("FAIL to_strobe_unexpected: got data %h required no strobe", pi_data);
                        end else begin
                            e = exp_tx.pop_front();
                            if (pi_data !== e) begin n_fail++; $display("FAIL to_data: got %h required %h", pi_data, e); end
                        end
                    end
                end
            end
        join
        n_checks++; if (cyc0 < 0 || cyc1 - cyc0 != 6) begin n_fail++; $display("FAIL to_strobe_gap: got %0d required 6", cyc1 - cyc0); end
        exp_tx.delete();
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        int f0;
        model_en = 1'b0; busy_force = 1'b1;
        f0 = flag_cnt;
        for (int i = 0; i < 17; i++) apb_write(4'h0, 32'(i));
        @(negedge clk); #1;
        n_checks++; if (flag_cnt != f0) begin n_fail++; $display("FAIL ovf_no_strobe: got %0d strobes required 0", flag_cnt - f0); end
        apb_read(4'hC, d);
        n_checks++; if (d !== 32'h00100000) begin n_fail++; $display("FAIL ovf_count: got %h required %h", d, 32'h00100000); end
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h00000069) begin n_fail++; $display("FAIL ovf_status: got %h required %h", d, 32'h69); end
        apb_write(4'h4, 32'h20);
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h00000049) begin n_fail++; $display("FAIL ovf_clear: got %h required %h", d, 32'h49); end
        busy_force = 1'b0;
        do_reset();
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        logic [7:0] e;
        exp_rx.push_back(8'h55); push_rx(8'h55);
        exp_rx.push_back(8'hAA); push_rx(8'hAA);
        apb_read(4'hC, d);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL rx_count2: got %h required 2", d); end
        for (int i = 0; i < 2; i++) begin
            apb_read(4'h0, d);
            e = exp_rx.pop_front();
            n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL rx_read: got %h required %h", d, e); end
        end
        apb_read(4'h0, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read: got %h required 0", d); end
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h0A) begin n_fail++; $display("FAIL rx_empty_status: got %h required 0a", d); end
    endtask

    task automatic test_rx_full();
        logic [31:0] d;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            exp_rx.push_back(8'(8'h10 + i)); push_rx(8'(8'h10 + i));
        end
        apb_read(4'hC, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL full_count: got %h required 10", d); end
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h06) begin n_fail++; $display("FAIL full_status: got %h required 06", d); end
        e = exp_rx.pop_front();
        exp_rx.push_back(8'hEE);
        apb_read(4'h0, d, 1'b1, 8'hEE);
        n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL full_pop_push_data: got %h required %h", d, e); end
        apb_read(4'hC, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL full_pop_push_count: got %h required 10", d); end
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h06) begin n_fail++; $display("FAIL full_pop_push_no_ovr: got %h required 06", d); end
        push_rx(8'h77);
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h16) begin n_fail++; $display("FAIL full_ovr_set: got %h required 16", d); end
        for (int i = 0; i < 16; i++) begin
            apb_read(4'h0, d);
            e = exp_rx.pop_front();
            n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL full_drain[%0d]: got %h required %h", i, d, e); end
        end
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h1A) begin n_fail++; $display("FAIL full_drained_status: got %h required 1a", d); end
        apb_write(4'h4, 32'h10);
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h0A) begin n_fail++; $display("FAIL ovr_clear: got %h required 0a", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [7:0] e;
        apb_write(4'h8, 32'hFF);
        apb_read(4'h8, d);
        n_checks++; if (d !== 32'h7) begin n_fail++; $display("FAIL ctrl_mask: got %h required 7", d); end
        apb_write(4'h8, 32'h1);
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b required 0", irq); end
        exp_rx.push_back(8'h99); push_rx(8'h99);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_same_cycle: got %b required 0", irq); end
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b required 1", irq); end
        apb_read(4'h0, d);
        e = exp_rx.pop_front();
        n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL irq_read: got %h required %h", d, e); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold_at_pop: got %b required 1", irq); end
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b required 0", irq); end
        apb_write(4'h8, 32'h0);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int f0;
        bit seen = 0;
        model_en = 1'b1;
        for (int i = 0; i < 4; i++) apb_write(4'h0, 32'(8'hA0 + i));
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk); #1;
            if (tx_busy === 1'b1) seen = 1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_busy_wait: got no busy required busy within 50 cycles"); end
        repeat (10) @(posedge clk);
        #1;
        apb_read(4'hC, d);
        n_checks++; if (d !== 32'h00030000) begin n_fail++; $display("FAIL mid_queued: got %h required %h", d, 32'h00030000); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_checks++; if (pi_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_pi_data: got %h required 00", pi_data); end
        n_checks++; if (pi_flag !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pi_flag: got %b required 0", pi_flag); end
        n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_prdata: got %h required 0", prdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq: got %b required 0", irq); end
        model_en = 1'b0; busy_force = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        f0 = flag_cnt;
        apb_read(4'h4, d);
        n_checks++; if (d !== 32'h0A) begin n_fail++; $display("FAIL mid_status_after: got %h required 0a", d); end
        apb_read(4'hC, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_count_after: got %h required 0", d); end
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (flag_cnt != f0) begin n_fail++; $display("FAIL mid_no_launch: got %0d strobes required 0", flag_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_tx_launch();
        test_timeout();
        test_tx_overflow();
        test_rx_basic();
        test_rx_full();
        test_irq();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
